id_decode_stage: RTL and testbench

Instruction-decode stage of the 5-stage pipeline. It sits directly downstream of the fetch stage and consumes its IF/ID npc and instruction outputs. It holds the 32x32 register file, which the MEM/WB stage writes back into, and decodes the opcode into WB/M/EX control bundles. It sign-extends the immediate and registers everything into the ID/EX latch for the execute stage.

---
 rtl/id_decode_stage_pkg.sv | 72 +++++++
 rtl/id_decode_stage_register_file.sv | 51 +++++
 rtl/id_decode_stage.sv | 123 ++++++++++++
 tb/tb_id_decode_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/id_decode_stage_pkg.sv
// Shared definitions for the ID stage: opcode values, ALU op encodings,
// control bundle widths, bit positions inside each bundle, and the
// opcode -> control decoder used by id_decode_stage.
package id_decode_stage_pkg;

    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // WB bundle: {regwrite, memtoreg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    // M bundle: {branch, memread, memwrite}
    localparam int M_BRANCH   = 2;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 0;
    // EX bundle: {regdst, aluop[1:0], alusrc}
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } ctrl_t;

    // An all-zero word is a nop even though its opcode field matches R-type,
    // so it must not raise regwrite.
    function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
        ctrl_t c;
        c = '0;
        if (instr != 32'h0) begin
            case (instr[31:26])
                OP_RTYPE: begin
                    c.wb[WB_REGWRITE]                = 1'b1;
                    c.ex[EX_REGDST]                  = 1'b1;
                    c.ex[EX_ALUOP_HI:EX_ALUOP_LO]    = ALUOP_FUNCT;
                end
                OP_LW: begin
                    c.wb[WB_REGWRITE]                = 1'b1;
                    c.wb[WB_MEMTOREG]                = 1'b1;
                    c.m[M_MEMREAD]                   = 1'b1;
                    c.ex[EX_ALUOP_HI:EX_ALUOP_LO]    = ALUOP_ADD;
                    c.ex[EX_ALUSRC]                  = 1'b1;
                end
                OP_SW: begin
                    c.m[M_MEMWRITE]                  = 1'b1;
                    c.ex[EX_ALUOP_HI:EX_ALUOP_LO]    = ALUOP_ADD;
                    c.ex[EX_ALUSRC]                  = 1'b1;
                end
                OP_BEQ: begin
                    c.m[M_BRANCH]                    = 1'b1;
                    c.ex[EX_ALUOP_HI:EX_ALUOP_LO]    = ALUOP_SUB;
                end
                default: c = '0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/id_decode_stage_register_file.sv
// 32-entry register file for the ID stage.
// Ports:
//   clk, rst_n          clock, async active-low clear of all entries
//   we, waddr, wdata    write-back port (writes to r0 dropped)
//   raddr1/2, rdata1/2  combinational read ports; a same-cycle write to the
//                       addressed register is forwarded onto the read data
module register_file
    import id_decode_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic                            wr_hit;

    assign wr_hit = we && (waddr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_hit) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '0;
        else        regs_q <= regs_d;
    end

    // r0 reads zero explicitly; the bypass lets the ID/EX latch capture
    // the value being written back in the same cycle.
    always_comb begin
        rdata1 = regs_q[raddr1];
        rdata2 = regs_q[raddr2];
        if (wr_hit && waddr == raddr1) rdata1 = wdata;
        if (wr_hit && waddr == raddr2) rdata2 = wdata;
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end

endmodule

// File: rtl/id_decode_stage.sv
// Instruction-decode stage: register file read, control decode, immediate
// sign-extension and the ID/EX pipeline latch.
// Ports:
//   clk, reset           clock, async active-low reset
//   if_id_npc/instr      IF/ID latch contents
//   flush                load a bubble into ID/EX at the next edge
//   mem_wb_*             register write-back port
//   id_ex_*              ID/EX latch outputs for the execute stage
module id_decode_stage
    import id_decode_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] if_id_npc,
    input  logic [31:0]       if_id_instr,
    input  logic              flush,
    input  logic              mem_wb_regwrite,
    input  logic [REG_AW-1:0] mem_wb_write_reg,
    input  logic [DATA_W-1:0] mem_wb_write_data,
    output logic [1:0]        id_ex_wb,
    output logic [2:0]        id_ex_m,
    output logic [3:0]        id_ex_ex,
    output logic [DATA_W-1:0] id_ex_npc,
    output logic [DATA_W-1:0] id_ex_readdat1,
    output logic [DATA_W-1:0] id_ex_readdat2,
    output logic [DATA_W-1:0] id_ex_sign_ext,
    output logic [REG_AW-1:0] id_ex_instr_2016,
    output logic [REG_AW-1:0] id_ex_instr_1511
);

    logic [DATA_W-1:0] rf_rd1, rf_rd2;
    ctrl_t             ctrl;

    logic [WB_W-1:0]   wb_d,   wb_q;
    logic [M_W-1:0]    m_d,    m_q;
    logic [EX_W-1:0]   ex_d,   ex_q;
    logic [DATA_W-1:0] npc_d,  npc_q;
    logic [DATA_W-1:0] rd1_d,  rd1_q;
    logic [DATA_W-1:0] rd2_d,  rd2_q;
    logic [DATA_W-1:0] sext_d, sext_q;
    logic [REG_AW-1:0] rt_d,   rt_q;
    logic [REG_AW-1:0] rd_d,   rd_q;

    register_file #(
        .DATA_W   (DATA_W),
        .REG_AW   (REG_AW),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (reset),
        .we     (mem_wb_regwrite),
        .waddr  (mem_wb_write_reg),
        .wdata  (mem_wb_write_data),
        .raddr1 (if_id_instr[25:21]),
        .raddr2 (if_id_instr[20:16]),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

    always_comb begin
        ctrl   = decode_ctrl(if_id_instr);
        wb_d   = ctrl.wb;
        m_d    = ctrl.m;
        ex_d   = ctrl.ex;
        npc_d  = if_id_npc;
        rd1_d  = rf_rd1;
        rd2_d  = rf_rd2;
        sext_d = {{(DATA_W-16){if_id_instr[15]}}, if_id_instr[15:0]};
        rt_d   = if_id_instr[20:16];
        rd_d   = if_id_instr[15:11];
        // A flush squashes the whole latch, not just the control bits.
        if (flush) begin
            wb_d   = '0;
            m_d    = '0;
            ex_d   = '0;
            npc_d  = '0;
            rd1_d  = '0;
            rd2_d  = '0;
            sext_d = '0;
            rt_d   = '0;
            rd_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_q   <= '0;
            m_q    <= '0;
            ex_q   <= '0;
            npc_q  <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            sext_q <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
        end else begin
            wb_q   <= wb_d;
            m_q    <= m_d;
            ex_q   <= ex_d;
            npc_q  <= npc_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            sext_q <= sext_d;
            rt_q   <= rt_d;
            rd_q   <= rd_d;
        end
    end

    assign id_ex_wb         = wb_q;
    assign id_ex_m          = m_q;
    assign id_ex_ex         = ex_q;
    assign id_ex_npc        = npc_q;
    assign id_ex_readdat1   = rd1_q;
    assign id_ex_readdat2   = rd2_q;
    assign id_ex_sign_ext   = sext_q;
    assign id_ex_instr_2016 = rt_q;
    assign id_ex_instr_1511 = rd_q;

endmodule

// File: tb/tb_id_decode_stage.sv
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_id_npc;
    logic [31:0] if_id_instr;
    logic        flush;
    logic        mem_wb_regwrite;
    logic [4:0]  mem_wb_write_reg;
    logic [31:0] mem_wb_write_data;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_m;
    logic [3:0]  id_ex_ex;
    logic [31:0] id_ex_npc;
    logic [31:0] id_ex_readdat1;
    logic [31:0] id_ex_readdat2;
    logic [31:0] id_ex_sign_ext;
    logic [4:0]  id_ex_instr_2016;
    logic [4:0]  id_ex_instr_1511;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_decode_stage dut (
        .clk               (clk),
        .reset             (reset),
        .if_id_npc         (if_id_npc),
        .if_id_instr       (if_id_instr),
        .flush             (flush),
        .mem_wb_regwrite   (mem_wb_regwrite),
        .mem_wb_write_reg  (mem_wb_write_reg),
        .mem_wb_write_data (mem_wb_write_data),
        .id_ex_wb          (id_ex_wb),
        .id_ex_m           (id_ex_m),
        .id_ex_ex          (id_ex_ex),
        .id_ex_npc         (id_ex_npc),
        .id_ex_readdat1    (id_ex_readdat1),
        .id_ex_readdat2    (id_ex_readdat2),
        .id_ex_sign_ext    (id_ex_sign_ext),
        .id_ex_instr_2016  (id_ex_instr_2016),
        .id_ex_instr_1511  (id_ex_instr_1511)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".wb"},   32'(id_ex_wb), 32'h0);
        chk({tag, ".m"},    32'(id_ex_m), 32'h0);
        chk({tag, ".ex"},   32'(id_ex_ex), 32'h0);
        chk({tag, ".npc"},  id_ex_npc, 32'h0);
        chk({tag, ".rd1"},  id_ex_readdat1, 32'h0);
        chk({tag, ".rd2"},  id_ex_readdat2, 32'h0);
        chk({tag, ".sext"}, id_ex_sign_ext, 32'h0);
        chk({tag, ".rt"},   32'(id_ex_instr_2016), 32'h0);
        chk({tag, ".rd"},   32'(id_ex_instr_1511), 32'h0);
    endtask

    initial begin
        // Reset held with busy inputs, including a write-back that must be dropped
        reset             = 1'b0;
        if_id_npc         = 32'h0000_0040;
        if_id_instr       = 32'h00A5_3020;
        flush             = 1'b0;
        mem_wb_regwrite   = 1'b1;
        mem_wb_write_reg  = 5'd5;
        mem_wb_write_data = 32'hAAAA_5555;
        step();
        step();
        chk_zero("reset");
        @(negedge clk);
        reset           = 1'b1;
        mem_wb_regwrite = 1'b0;

        // Every register reads zero after reset (rs = rt = i)
        for (int i = 1; i < 32; i++) begin
            if_id_instr = {6'h00, 5'(i), 5'(i), 16'h0000};
            step();
            chk($sformatf("rst_r%0d_a", i), id_ex_readdat1, 32'h0);
            chk($sformatf("rst_r%0d_b", i), id_ex_readdat2, 32'h0);
        end

        // Write r5 then read it as both operands of add r6,r5,r5
        mem_wb_regwrite   = 1'b1;
        mem_wb_write_reg  = 5'd5;
        mem_wb_write_data = 32'hDEAD_BEEF;
        if_id_instr       = 32'h0000_0000;
        step();
        chk("nop.wb", 32'(id_ex_wb), 32'h0);
        chk("nop.ex", 32'(id_ex_ex), 32'h0);
        mem_wb_regwrite = 1'b0;
        if_id_instr     = 32'h00A5_3020;
        if_id_npc       = 32'h0000_0100;
        step();
        chk("add.rd1", id_ex_readdat1, 32'hDEAD_BEEF);
        chk("add.rd2", id_ex_readdat2, 32'hDEAD_BEEF);
        chk("add.wb",  32'(id_ex_wb), 32'h2);
        chk("add.m",   32'(id_ex_m), 32'h0);
        chk("add.ex",  32'(id_ex_ex), 32'hC);
        chk("add.rd",  32'(id_ex_instr_1511), 32'd6);
        chk("add.rt",  32'(id_ex_instr_2016), 32'd5);
        chk("add.npc", id_ex_npc, 32'h0000_0100);

        // Same-cycle write/read bypass: lw r9, 4(r8)
        mem_wb_regwrite   = 1'b1;
        mem_wb_write_reg  = 5'd8;
        mem_wb_write_data = 32'h1234_5678;
        if_id_instr       = 32'h8D09_0004;
        step();
        chk("lw.rd1",  id_ex_readdat1, 32'h1234_5678);
        chk("lw.rd2",  id_ex_readdat2, 32'h0);
        chk("lw.sext", id_ex_sign_ext, 32'h4);
        chk("lw.wb",   32'(id_ex_wb), 32'h3);
        chk("lw.m",    32'(id_ex_m), 32'h2);
        chk("lw.ex",   32'(id_ex_ex), 32'h1);
        chk("lw.rt",   32'(id_ex_instr_2016), 32'd9);

        // r0 write ignored, no bypass onto r0; rt=r8 now from storage
        mem_wb_write_reg  = 5'd0;
        mem_wb_write_data = 32'hFFFF_FFFF;
        if_id_instr       = 32'h0008_0000;
        step();
        chk("r0_byp.rd1", id_ex_readdat1, 32'h0);
        chk("r0_byp.rd2", id_ex_readdat2, 32'h1234_5678);
        mem_wb_regwrite = 1'b0;
        step();
        chk("r0_rd.rd1", id_ex_readdat1, 32'h0);

        // beq r4,r5,-4 with negative immediate
        if_id_instr = 32'h1085_FFFC;
        if_id_npc   = 32'h0000_0104;
        step();
        chk("beq.sext", id_ex_sign_ext, 32'hFFFF_FFFC);
        chk("beq.m",    32'(id_ex_m), 32'h4);
        chk("beq.ex",   32'(id_ex_ex), 32'h2);
        chk("beq.wb",   32'(id_ex_wb), 32'h0);
        chk("beq.npc",  id_ex_npc, 32'h0000_0104);
        chk("beq.rd2",  id_ex_readdat2, 32'hDEAD_BEEF);

        // Unknown opcode (0x08) decodes to no control
        if_id_instr = 32'h2000_0000;
        step();
        chk("unk.wb", 32'(id_ex_wb), 32'h0);
        chk("unk.m",  32'(id_ex_m), 32'h0);
        chk("unk.ex", 32'(id_ex_ex), 32'h0);

        // Flush a sw while writing r10; the write must still land
        if_id_instr       = 32'hAD0A_0008;
        flush             = 1'b1;
        mem_wb_regwrite   = 1'b1;
        mem_wb_write_reg  = 5'd10;
        mem_wb_write_data = 32'hCAFE_0001;
        step();
        chk_zero("flush");
        flush           = 1'b0;
        mem_wb_regwrite = 1'b0;
        step();
        chk("sw.m",    32'(id_ex_m), 32'h1);
        chk("sw.wb",   32'(id_ex_wb), 32'h0);
        chk("sw.ex",   32'(id_ex_ex), 32'h1);
        chk("sw.rd1",  id_ex_readdat1, 32'h1234_5678);
        chk("sw.rd2",  id_ex_readdat2, 32'hCAFE_0001);
        chk("sw.sext", id_ex_sign_ext, 32'h8);

        // Asynchronous reset mid-cycle, with flush also asserted
        if_id_instr = 32'h00A5_3020;
        step();
        chk("pre_arst.wb", 32'(id_ex_wb), 32'h2);
        #2;
        flush = 1'b1;
        reset = 1'b0;
        #1;
        chk_zero("arst");
        @(negedge clk);
        reset = 1'b1;
        flush = 1'b0;
        step();
        chk("post_arst.r5", id_ex_readdat1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
